// File: rtl/stream_pkg.sv
// Shared definitions for the stream width converters: lane index sizing and type.
package stream_pkg;

    localparam int LANE_IDX_W = 16;

    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    // A 2-lane converter still needs one index bit, so the width never drops below 1.
    function automatic int idx_width(input int ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/stream_upsizer_if.sv
// Narrow-in / wide-out handshake bundle for stream_upsizer.
// in_last/out_last exist only when STREAM_UPSIZER_FLUSH_EN is defined.
interface stream_upsizer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4
);
    logic [DATA_WIDTH-1:0]       in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic [DATA_WIDTH*RATIO-1:0] out_data;
    logic [RATIO-1:0]            out_keep;
    logic                        out_valid;
    logic                        out_ready;
`ifdef STREAM_UPSIZER_FLUSH_EN
    logic                        in_last;
    logic                        out_last;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_keep, out_last, out_valid
    );
    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_keep, out_last, out_valid
    );
`else
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_keep, out_valid
    );
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_keep, out_valid
    );
`endif
endinterface

// File: rtl/stream_upsizer.sv
// Packs RATIO narrow beats (lane 0 first) into one wide word with a keep mask.
// STREAM_UPSIZER_FLUSH_EN adds in_last/out_last and early completion of partial words.
module stream_upsizer
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    stream_upsizer_if.slave  bus
);

    localparam int IDX_WIDTH = idx_width(RATIO);
    localparam int WORD_W    = DATA_WIDTH * RATIO;
    localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(RATIO - 1);

    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic [WORD_W-1:0]    asm_q, asm_d;
    logic [WORD_W-1:0]    out_data_q, out_data_d;
    logic [RATIO-1:0]     out_keep_q, out_keep_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;

    logic last_beat;
    logic completing;
    logic in_ready;
    logic accept;

    always_comb begin
        last_beat = 1'b0;
`ifdef STREAM_UPSIZER_FLUSH_EN
        last_beat = bus.in_last;
`endif
        completing = (idx_q == IDX_LAST) | last_beat;
        // Only a completing beat needs the output register, so only it can stall.
        in_ready   = ~completing | ~out_valid_q | bus.out_ready;
        accept     = bus.in_valid & in_ready;

        idx_d       = idx_q;
        asm_d       = asm_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (completing) begin
                for (int k = 0; k < RATIO; k++) begin
                    if (lane_idx_t'(k) < lane_idx_t'(idx_q)) begin
                        out_data_d[k*DATA_WIDTH +: DATA_WIDTH] = asm_q[k*DATA_WIDTH +: DATA_WIDTH];
                        out_keep_d[k] = 1'b1;
                    end else if (lane_idx_t'(k) == lane_idx_t'(idx_q)) begin
                        out_data_d[k*DATA_WIDTH +: DATA_WIDTH] = bus.in_data;
                        out_keep_d[k] = 1'b1;
                    end else begin
                        out_data_d[k*DATA_WIDTH +: DATA_WIDTH] = '0;
                        out_keep_d[k] = 1'b0;
                    end
                end
                out_valid_d = 1'b1;
                out_last_d  = last_beat;
                idx_d       = '0;
                asm_d       = '0;
            end else begin
                for (int k = 0; k < RATIO; k++) begin
                    if (lane_idx_t'(k) == lane_idx_t'(idx_q)) begin
                        asm_d[k*DATA_WIDTH +: DATA_WIDTH] = bus.in_data;
                    end
                end
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            asm_q       <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            asm_q       <= asm_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_keep  = out_keep_q;
    assign bus.out_valid = out_valid_q;
`ifdef STREAM_UPSIZER_FLUSH_EN
    assign bus.out_last  = out_last_q;
`else
    logic unused_last;
    assign unused_last = out_last_q;
`endif

endmodule
